// File: rtl/shift_reg_rx_pkg.sv
// Project-wide constants shared between the serial transmitter and receiver.
package shift_reg_rx_pkg;

    localparam int unsigned FRAME_WIDTH         = 48;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage : shift_reg_rx_pkg

// File: rtl/shift_reg_rx_if.sv
// Three-wire serial frame bus (clock, data, latch) between transmitter and receiver.
interface shift_reg_rx_if;

    logic sclk;
    logic data;
    logic latch;

    modport master (output sclk, output data, output latch);
    modport slave  (input  sclk, input  data, input  latch);

endinterface : shift_reg_rx_if

// File: rtl/shift_reg_rx_sync_edge.sv
// Input synchronizer with one-cycle-delayed copy for rise/fall pulse detection.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync_s;
    logic prev_q;

    generate
        if (STAGES > 0) begin : g_sync
            logic [STAGES-1:0] chain_q;

            // Synchronizer chain, preloaded with the idle level of the line.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    chain_q <= {STAGES{RESET_VAL}};
                end else begin
                    chain_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) begin
                        chain_q[i] <= chain_q[i-1];
                    end
                end
            end

            assign sync_s = chain_q[STAGES-1];
        end else begin : g_bypass
            assign sync_s = d_i;
        end
    endgenerate

    // Delayed copy used as the reference for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= sync_s;
        end
    end

    assign q_o    = sync_s;
    assign rise_o = sync_s & ~prev_q;
    assign fall_o = ~sync_s & prev_q;

endmodule : sync_edge

// File: rtl/shift_reg_rx.sv
// Serial frame receiver: shifts MSB-first bits on sclk rising edges, closes the
// frame on latch rising edge and reports a good frame (valid) or bad count (error).
module shift_reg_rx
    import shift_reg_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = FRAME_WIDTH,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    shift_reg_rx_if.slave    ser_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             error_o,
    output logic             busy_o
);

    localparam int unsigned           CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]      CNT_SAT  = CNT_W'(WIDTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic data_s, data_rise_s, data_fall_s;
    logic latch_s, latch_rise_s, latch_fall_s;
    logic unused_s;

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q,  shreg_d;
    logic [WIDTH-1:0]   data_q,   data_d;
    logic               valid_q,  valid_d;
    logic               error_q,  error_d;
    logic               busy_q;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (ser_i.sclk),
        .q_o (sclk_s), .rise_o (sclk_rise_s), .fall_o (sclk_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (ser_i.data),
        .q_o (data_s), .rise_o (data_rise_s), .fall_o (data_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_latch (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (ser_i.latch),
        .q_o (latch_s), .rise_o (latch_rise_s), .fall_o (latch_fall_s)
    );

    // Only the edges feeding the frame logic are consumed; the rest are sunk here.
    assign unused_s = ^{sclk_s, sclk_fall_s, data_rise_s, data_fall_s, latch_s};

    // Frame state, bit counting, shifting and end-of-frame classification.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (latch_fall_s) begin
                    state_d = ST_SHIFT;
                    if (sclk_rise_s) begin
                        shreg_d   = {shreg_q[WIDTH-2:0], data_s};
                        bit_cnt_d = CNT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (latch_rise_s) begin
                    // Latch wins over a coincident sclk edge: that bit is dropped.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if (bit_cnt_q == CNT_FULL) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else if (bit_cnt_q != '0) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                    end
                end else if (sclk_rise_s) begin
                    shreg_d = {shreg_q[WIDTH-2:0], data_s};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            busy_q    <= (bit_cnt_d != '0);
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign error_o = error_q;
    assign busy_o  = busy_q;

endmodule : shift_reg_rx
